// File: rtl/mem_stage.sv
// mem_stage: memory stage of a 5-stage RV32I pipeline.
//
// Holds the EX/MEM pipeline register, a byte-addressed synchronous data RAM
// (LB/LH/LW/LBU/LHU/SB/SH/SW), and the MEM/WB pipeline register.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   stall             freezes both pipeline registers, the RAM read register and RAM writes
//   ex_result         ALU result; byte address for loads and stores
//   ex_write_data     store data
//   ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_size (funct3)
//   mem_forward, mem_rd, mem_reg_write, mem_mem_read   EX/MEM register outputs
//   wb_data, wb_rd, wb_reg_write, wb_fault              MEM/WB register outputs
module mem_stage #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned REG_SEL   = $clog2(NUM_REGS),
    parameter int unsigned ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [WORD_SIZE-1:0] ex_result,
    input  logic [WORD_SIZE-1:0] ex_write_data,
    input  logic [REG_SEL-1:0]   ex_rd,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic [2:0]           ex_mem_size,
    output logic [WORD_SIZE-1:0] mem_forward,
    output logic [REG_SEL-1:0]   mem_rd,
    output logic                 mem_reg_write,
    output logic                 mem_mem_read,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic [REG_SEL-1:0]   wb_rd,
    output logic                 wb_reg_write,
    output logic                 wb_fault
);

    localparam int unsigned NumWords = 2 ** (ADDR_SIZE - 2);

    // Word-organised RAM with four byte lanes; zero only at time 0, never on reset.
    logic [3:0][7:0] ram [NumWords] = '{default: '0};
    logic [31:0]     rdata_q;

    // EX/MEM side-band fields needed to format the load in the next cycle.
    logic [2:0] mem_size_q;
    logic [1:0] mem_off_q;
    logic       mem_fault_q;

    // EX-side decode.
    logic [ADDR_SIZE-3:0] ex_word_addr;
    logic [1:0]           ex_off;
    logic                 ex_bad;
    logic                 ex_fault;
    logic [3:0]           ex_be;
    logic [31:0]          ex_sdata;
    logic                 ram_we;

    always_comb begin
        ex_word_addr = ex_result[ADDR_SIZE-1:2];
        ex_off       = ex_result[1:0];
        ex_bad       = 1'b0;
        ex_be        = 4'b0000;
        ex_sdata     = '0;
        case (ex_mem_size)
            3'b000, 3'b100: begin
                ex_be    = 4'b0001 << ex_off;
                ex_sdata = {4{ex_write_data[7:0]}};
            end
            3'b001, 3'b101: begin
                ex_bad   = ex_off[0];
                ex_be    = ex_off[1] ? 4'b1100 : 4'b0011;
                ex_sdata = {2{ex_write_data[15:0]}};
            end
            3'b010: begin
                ex_bad   = |ex_off;
                ex_be    = 4'b1111;
                ex_sdata = ex_write_data[31:0];
            end
            default: ex_bad = 1'b1;
        endcase
        // Only loads and stores can fault; funct3 is meaningless otherwise.
        ex_fault = (ex_mem_read | ex_mem_write) & ex_bad;
        ram_we   = ex_mem_write & ~stall & ~rst & ~ex_fault;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ex_be[i]) begin
                    ram[ex_word_addr][i] <= ex_sdata[8*i +: 8];
                end
            end
        end
    end

    // Read register is not reset: its value is only consumed behind mem_mem_read.
    always_ff @(posedge clk) begin
        if (!stall) begin
            rdata_q <= ram[ex_word_addr];
        end
    end

    // EX/MEM register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_forward   <= '0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_size_q    <= '0;
            mem_off_q     <= '0;
            mem_fault_q   <= 1'b0;
        end else if (!stall) begin
            mem_forward   <= ex_result;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            mem_size_q    <= ex_mem_size;
            mem_off_q     <= ex_off;
            mem_fault_q   <= ex_fault;
        end
    end

    // Load formatting from the registered word.
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [WORD_SIZE-1:0] ld_val;
    logic [WORD_SIZE-1:0] wb_data_d;

    always_comb begin
        case (mem_off_q)
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = mem_off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (mem_size_q)
            3'b000:  ld_val = {{(WORD_SIZE-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {{(WORD_SIZE-8){1'b0}}, ld_byte};
            3'b001:  ld_val = {{(WORD_SIZE-16){ld_half[15]}}, ld_half};
            3'b101:  ld_val = {{(WORD_SIZE-16){1'b0}}, ld_half};
            3'b010:  ld_val = WORD_SIZE'(rdata_q);
            default: ld_val = '0;
        endcase
        if (mem_fault_q) begin
            ld_val = '0;
        end
        wb_data_d = mem_mem_read ? ld_val : mem_forward;
    end

    // MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b0;
        end else if (!stall) begin
            wb_data      <= wb_data_d;
            wb_rd        <= mem_rd;
            wb_reg_write <= mem_reg_write;
            wb_fault     <= mem_fault_q;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. The driver runs each issued
// instruction through a byte-array reference model and queues the expected
// EX/MEM and MEM/WB contents; the monitor pops and compares after every edge.
module tb_mem_stage;

    localparam int W  = 32;
    localparam int RS = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic [W-1:0]  ex_result;
    logic [W-1:0]  ex_write_data;
    logic [RS-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic [2:0]    ex_mem_size;
    logic [W-1:0]  mem_forward;
    logic [RS-1:0] mem_rd;
    logic          mem_reg_write;
    logic          mem_mem_read;
    logic [W-1:0]  wb_data;
    logic [RS-1:0] wb_rd;
    logic          wb_reg_write;
    logic          wb_fault;

    mem_stage #(
        .WORD_SIZE(32),
        .NUM_REGS (32),
        .ADDR_SIZE(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .ex_result    (ex_result),
        .ex_write_data(ex_write_data),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_mem_size  (ex_mem_size),
        .mem_forward  (mem_forward),
        .mem_rd       (mem_rd),
        .mem_reg_write(mem_reg_write),
        .mem_mem_read (mem_mem_read),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_fault     (wb_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fwd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [31:0] wdata;
        logic [4:0]  wrd;
        logic        wrw;
        logic        wfault;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  model_mem [1024];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: executes one instruction on a flat byte memory.
    function automatic exp_t model(input logic [31:0] result, input logic [31:0] wd,
                                   input logic [4:0] rd, input logic rw, input logic mr,
                                   input logic mw, input logic [2:0] size);
        exp_t        e;
        int          addr;
        int          nb;
        bit          sg;
        bit          legal;
        bit          fault;
        logic [31:0] v;
        addr  = int'(result % 1024);
        nb    = 1;
        sg    = 0;
        legal = 1;
        case (size)
            3'd0: begin nb = 1; sg = 1; end
            3'd4: nb = 1;
            3'd1: begin nb = 2; sg = 1; end
            3'd5: nb = 2;
            3'd2: nb = 4;
            default: legal = 0;
        endcase
        fault = (mr || mw) && (!legal || (addr % nb) != 0);
        if (mw && !fault) begin
            for (int i = 0; i < nb; i++) model_mem[addr + i] = 8'(wd >> (8 * i));
        end
        v = 0;
        if (!fault) begin
            for (int i = 0; i < nb; i++) v = v | (32'(model_mem[addr + i]) << (8 * i));
            if (sg && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        e.fwd    = result;
        e.rd     = rd;
        e.rw     = rw;
        e.mr     = mr;
        e.wdata  = mr ? v : result;
        e.wrd    = rd;
        e.wrw    = rw;
        e.wfault = fault;
        return e;
    endfunction

    task automatic issue(input logic [31:0] result, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic [2:0] size);
        @(negedge clk);
        rst           = 1'b0;
        stall         = 1'b0;
        ex_result     = result;
        ex_write_data = wd;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_mem_size   = size;
        q.push_back(model(result, wd, rd, rw, mr, mw, size));
    endtask

    task automatic randomize_ex();
        ex_result     = $urandom;
        ex_write_data = $urandom;
        ex_rd         = 5'($urandom);
        ex_reg_write  = 1'($urandom);
        ex_mem_read   = 1'($urandom);
        ex_mem_write  = 1'b1;
        ex_mem_size   = 3'($urandom);
    endtask

    // Stalled cycle with an aligned word store presented; it must not land.
    task automatic stall_cycle(input logic [31:0] addr);
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b1;
        randomize_ex();
        ex_result   = addr & ~32'h3;
        ex_mem_size = 3'b010;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst   = 1'b1;
            stall = 1'($urandom);
            randomize_ex();
            q.delete();
        end
    endtask

    // Monitor.
    initial begin
        exp_t cur_m;
        exp_t cur_w;
        exp_t zero;
        bit   primed;
        logic s_rst;
        logic s_stall;
        zero   = '{fwd: 0, rd: 0, rw: 0, mr: 0, wdata: 0, wrd: 0, wrw: 0, wfault: 0};
        cur_m  = zero;
        cur_w  = zero;
        primed = 0;
        forever begin
            @(posedge clk);
            s_rst   = rst;
            s_stall = stall;
            #1;
            if (s_rst) begin
                cur_m  = zero;
                cur_w  = zero;
                primed = 0;
            end else if (!s_stall) begin
                if (primed) begin
                    if (q.size() == 0) begin
                        chk("scoreboard_underflow", 32'(q.size()), 32'd1);
                    end else begin
                        cur_w = q.pop_front();
                    end
                end
                if (q.size() > 0) cur_m = q[0];
                primed = 1;
            end
            chk("mem_forward", mem_forward, cur_m.fwd);
            chk("mem_rd", 32'(mem_rd), 32'(cur_m.rd));
            chk("mem_reg_write", 32'(mem_reg_write), 32'(cur_m.rw));
            chk("mem_mem_read", 32'(mem_mem_read), 32'(cur_m.mr));
            chk("wb_data", wb_data, cur_w.wdata);
            chk("wb_rd", 32'(wb_rd), 32'(cur_w.wrd));
            chk("wb_reg_write", 32'(wb_reg_write), 32'(cur_w.wrw));
            chk("wb_fault", 32'(wb_fault), 32'(cur_w.wfault));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Driver.
    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        int          kind;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
        rst   = 1'b1;
        stall = 1'b0;
        randomize_ex();

        do_reset(2);
        issue(32'h1234, 32'h0, 5'd5, 1, 0, 0, 3'b000);         // ALU pass-through
        issue(32'h40, 32'h8765ABCD, 5'd0, 0, 0, 1, 3'b010);    // SW
        issue(32'h40, 32'h0, 5'd1, 1, 1, 0, 3'b010);           // LW
        issue(32'h43, 32'h0, 5'd2, 1, 1, 0, 3'b000);           // LB
        issue(32'h43, 32'h0, 5'd3, 1, 1, 0, 3'b100);           // LBU
        issue(32'h42, 32'h0, 5'd4, 1, 1, 0, 3'b001);           // LH
        issue(32'h40, 32'h0, 5'd6, 1, 1, 0, 3'b101);           // LHU
        issue(32'h41, 32'h11, 5'd0, 0, 0, 1, 3'b000);          // SB
        issue(32'h40, 32'h0, 5'd7, 1, 1, 0, 3'b010);           // LW
        issue(32'h42, 32'hFFFFFFFF, 5'd0, 0, 0, 1, 3'b010);    // misaligned SW
        issue(32'h40, 32'h0, 5'd8, 1, 1, 0, 3'b010);           // LW
        issue(32'h01, 32'h0, 5'd9, 1, 1, 0, 3'b001);           // misaligned LH
        issue(32'h40, 32'h0, 5'd10, 1, 1, 0, 3'b011);          // illegal size load
        issue(32'h41, 32'h0, 5'd11, 1, 0, 0, 3'b111);          // ALU op, never faults
        issue(32'h40, 32'h0, 5'd12, 1, 1, 0, 3'b010);          // load held by stall
        for (int i = 0; i < 3; i++) stall_cycle(32'h40);
        issue(32'h0, 32'h0, 5'd0, 0, 0, 0, 3'b000);
        issue(32'h40, 32'h0, 5'd13, 1, 1, 0, 3'b010);          // RAM untouched by stall
        issue(32'h404, 32'hCAFEF00D, 5'd0, 0, 0, 1, 3'b010);   // wrap store
        issue(32'h004, 32'h0, 5'd14, 1, 1, 0, 3'b010);
        do_reset(2);                                           // RAM survives reset
        issue(32'h40, 32'h0, 5'd15, 1, 1, 0, 3'b010);

        for (int n = 0; n < 300; n++) begin
            a = {22'($urandom), 4'($urandom), 6'($urandom)};
            case ($urandom_range(0, 9))
                0, 1, 2, 3: sz = 3'b010;
                4: sz = 3'b000;
                5: sz = 3'b100;
                6: sz = 3'b001;
                7: sz = 3'b101;
                default: sz = 3'($urandom);
            endcase
            if (($urandom % 5) == 0) begin
                stall_cycle(a);
            end else begin
                kind = $urandom_range(0, 2);
                issue(a, $urandom, 5'($urandom), (kind != 2), (kind == 1), (kind == 2), sz);
            end
        end

        issue(32'h0, 32'h0, 5'd0, 0, 0, 0, 3'b000);
        issue(32'h0, 32'h0, 5'd0, 0, 0, 0, 3'b000);
        @(negedge clk);
        chk("queue_drain", 32'(q.size()), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
